// File: rtl/rom_bootcopy_ahb.sv
// rom_bootcopy_ahb: non-pipelined AHB manager that copies WORDS XLEN-bit words
// from the boot ROM (SRC_BASE) into RAM (DST_BASE) on a Start request.
// Each word is one read transfer followed by one write transfer.
// Optional feature macro: ROM_BOOTCOPY_CHECKSUM_EN enables a running XOR
// checksum of every word read; without it Checksum is tied to zero.

package cvw;
    typedef struct packed {
        int unsigned XLEN;
        int unsigned PA_BITS;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: 64, PA_BITS: 32};
endpackage

module rom_bootcopy_ahb #(
    parameter cvw::cvw_t            P        = cvw::CVW_DEFAULT,
    parameter logic [P.PA_BITS-1:0] SRC_BASE = '0,
    parameter logic [P.PA_BITS-1:0] DST_BASE = '0,
    parameter int unsigned          WORDS    = 16
) (
    input  logic                 HCLK,
    input  logic                 reset,
    input  logic                 Start,
    output logic [P.PA_BITS-1:0] HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [P.XLEN-1:0]    HWDATA,
    input  logic [P.XLEN-1:0]    HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error,
    output logic [P.XLEN-1:0]    Checksum
);

    localparam int unsigned XLEN  = P.XLEN;
    localparam int unsigned AW    = P.PA_BITS;
    localparam int unsigned CW    = $clog2(WORDS + 1);
    localparam int unsigned LOG2B = $clog2(XLEN / 8);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR,
        S_WR_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   haddr_q, haddr_d;
    logic [1:0]      htrans_q, htrans_d;
    logic            hwrite_q, hwrite_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
`ifdef ROM_BOOTCOPY_CHECKSUM_EN
    logic [XLEN-1:0] cks_q, cks_d;
`endif

    // Byte offset of word index c (address arithmetic wraps at AW bits).
    function automatic logic [AW-1:0] word_off(input logic [CW-1:0] c);
        return AW'(c) << LOG2B;
    endfunction

    // Next-state and next-output decode; address-phase outputs are computed
    // for the state being entered so they come straight from flops.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        buf_d    = buf_q;
        // Sticky flags follow the terminal state one edge later.
        done_d   = done_q  | (state_q == S_DONE);
        error_d  = error_q | (state_q == S_ERROR);
`ifdef ROM_BOOTCOPY_CHECKSUM_EN
        cks_d    = cks_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d  = S_RD_ADDR;
                    count_d  = '0;
                    haddr_d  = SRC_BASE;
                    htrans_d = HT_NONSEQ;
                    hwrite_d = 1'b0;
`ifdef ROM_BOOTCOPY_CHECKSUM_EN
                    cks_d    = '0;
`endif
                end
            end
            S_RD_ADDR: begin
                if (HREADY) begin
                    state_d  = S_RD_DATA;
                    htrans_d = HT_IDLE;
                end
            end
            S_RD_DATA: begin
                if (HREADY) begin
                    if (HRESP) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d  = S_WR_ADDR;
                        buf_d    = HRDATA;
                        haddr_d  = DST_BASE + word_off(count_q);
                        htrans_d = HT_NONSEQ;
                        hwrite_d = 1'b1;
`ifdef ROM_BOOTCOPY_CHECKSUM_EN
                        cks_d    = cks_q ^ HRDATA;
`endif
                    end
                end
            end
            S_WR_ADDR: begin
                if (HREADY) begin
                    state_d  = S_WR_DATA;
                    htrans_d = HT_IDLE;
                    hwrite_d = 1'b0;
                end
            end
            S_WR_DATA: begin
                if (HREADY) begin
                    if (HRESP) begin
                        state_d = S_ERROR;
                    end else if (count_q == CW'(WORDS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_RD_ADDR;
                        count_d  = count_q + CW'(1);
                        haddr_d  = SRC_BASE + word_off(count_q + CW'(1));
                        htrans_d = HT_NONSEQ;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge HCLK) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            haddr_q  <= '0;
            htrans_q <= HT_IDLE;
            hwrite_q <= 1'b0;
            buf_q    <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef ROM_BOOTCOPY_CHECKSUM_EN
            cks_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            buf_q    <= buf_d;
            done_q   <= done_d;
            error_q  <= error_d;
`ifdef ROM_BOOTCOPY_CHECKSUM_EN
            cks_q    <= cks_d;
`endif
        end
    end

    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HWRITE = hwrite_q;
    assign HSIZE  = 3'(LOG2B);
    assign HWDATA = buf_q;
    assign Busy   = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    assign Done   = done_q;
    assign Error  = error_q;
`ifdef ROM_BOOTCOPY_CHECKSUM_EN
    assign Checksum = cks_q;
`else
    assign Checksum = '0;
`endif

endmodule

// File: doc/rom_bootcopy_ahb.md
# rom_bootcopy_ahb

AHB manager that copies a block of words from the on-chip boot ROM into RAM on command, then reports completion. It sits on the uncore AHB fabric alongside the core's bus interface and is the ROM's immediate consumer during boot. One word per transfer, strictly non-pipelined: a read from ROM, then a write of that word to RAM. Status is reported through Busy/Done/Error.

## Interface
- P, none: cvw_t configuration; uses P.XLEN and P.PA_BITS.
- SRC_BASE, 0: byte address of the first ROM word; XLEN/8-aligned.
- DST_BASE, 0: byte address of the first RAM word; XLEN/8-aligned.
- WORDS, 16: number of XLEN words to copy; must be ≥1.
- HCLK  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Start  in  1  copy request, sampled only in IDLE.
- HADDR  out  P.PA_BITS  transfer address.
- HTRANS  out  2  2'b10 (NONSEQ) in address phases, 2'b00 (IDLE) otherwise.
- HWRITE  out  1  1 in the write address phase only.
- HSIZE  out  3  constant $clog2(P.XLEN/8).
- HWDATA  out  P.XLEN  buffered word, driven in the write data phase.
- HRDATA  in  P.XLEN  read data.
- HREADY  in  1  transfer complete / address accepted.
- HRESP  in  1  1 = error response.
- Busy  out  1  high in every state except IDLE, DONE and ERROR.
- Done  out  1  sticky completion flag.
- Error  out  1  sticky bus-error flag.
- Checksum  out  P.XLEN  XOR of all copied words; see Configuration.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE, ERROR.
- IDLE: HTRANS=00. If Start=1 at an edge, go to RD_ADDR, clear the word counter and clear the checksum.
- RD_ADDR: HTRANS=10, HWRITE=0, HADDR=SRC_BASE+count·(XLEN/8). Hold until HREADY=1 at an edge, then go to RD_DATA.
- RD_DATA: HTRANS=00. At the edge where HREADY=1:
  - HRESP=1: go to ERROR.
  - Otherwise: capture HRDATA into the word buffer and go to WR_ADDR.
- WR_ADDR: HTRANS=10, HWRITE=1, HADDR=DST_BASE+count·(XLEN/8). Hold until HREADY=1, then go to WR_DATA.
- WR_DATA: HTRANS=00, HWDATA=buffer. At the edge where HREADY=1:
  - HRESP=1: go to ERROR.
  - count==WORDS-1: go to DONE.
  - Otherwise: count+1 and go to RD_ADDR.
- DONE: Done=1. Terminal until reset; Start is ignored.
- ERROR: Error=1 and HADDR holds the faulting address. Terminal until reset.
- Counter width is $clog2(WORDS+1). Address arithmetic is modulo 2^PA_BITS with no bounds check.
- Start is ignored in every state except IDLE.

## Timing
- Reset values: state=IDLE, HTRANS=00, HWRITE=0, HADDR=0, HWDATA=0, Busy=0, Done=0, Error=0, Checksum=0, count=0.
- All outputs are registered or decoded from the state register only. No combinational path from any input to any output.
- With HREADY held at 1: 4 cycles per word, so Done rises 4·WORDS+1 edges after the edge that samples Start.
- Each HREADY=0 cycle adds one cycle to the phase it occurs in.
- HADDR, HTRANS and HWRITE stay stable across an address phase extended by HREADY=0.
- HWDATA stays stable across the whole write data phase.
- Reset asserted mid-transfer aborts the transfer immediately at the next edge. No completion is awaited and the block returns to IDLE with reset values.

## Configuration
- ROM_BOOTCOPY_CHECKSUM_EN defined:
  - Each word captured in RD_DATA is XORed into Checksum on the same edge.
  - Checksum is cleared on Start and holds its value in DONE and ERROR.
- Not defined: Checksum is tied to 0 and the accumulator register is removed.

## Test plan
- XLEN=64, WORDS=4, SRC_BASE=0x1000, DST_BASE=0x8000_0000, HREADY=1, ROM words 0x11..0x44: Start pulse → four read/write pairs at 0x1000/0x8000_0000 up to 0x1018/0x8000_0018; Done=1 exactly 17 edges after Start is sampled; RAM holds 0x11..0x44.
- Same setup with HREADY=0 for 3 cycles in the second read data phase → HADDR and HTRANS stable throughout; total latency 20 edges; data correct.
- HRESP=1 on the write of word 2 → ERROR state, Error=1, Done=0, HADDR=0x8000_0010, no further NONSEQ transfers.
- Start held at 1 through DONE, and Start pulses during Busy → exactly one copy is performed.
- reset asserted during WR_ADDR of word 1 → next cycle all outputs at reset values; a new Start restarts the copy from word 0.
- With ROM_BOOTCOPY_CHECKSUM_EN and words 0x11,0x22,0x44,0x88 → Checksum=0xFF at Done. Without the macro → Checksum=0.
